// File: rtl/module_pht.sv
// Gshare-style pattern history table with a checkpoint FIFO of in-flight
// predictions, resolved in order, with GHR repair on a mispredict.
module module_pht #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isbranch,
  input  logic [31:0] currentPC,
  input  logic        update,
  input  logic [31:0] branchPC,
  input  logic        taken,
  output logic        pred_taken,
  output logic        pred_valid,
  output logic        fifo_full,
  output logic        mispredict,
  output logic        sync_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int N_ENT = 1 << IDX_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [1:0]        pht    [N_ENT];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  f_idx  [DEPTH];
  logic [IDX_W-1:0]  f_pc   [DEPTH];
  logic [HIST_W-1:0] f_ghr  [DEPTH];
  logic              f_pred [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic [IDX_W-1:0]  ghr_ext;
  logic [IDX_W-1:0]  idx;
  logic              pred_bit;
  logic              fifo_empty;
  logic [IDX_W-1:0]  head_idx;
  logic [HIST_W-1:0] head_ghr;
  logic              head_pred;
  logic              upd_hit;
  logic              upd_mis;
  logic              pred_acc;
  logic [1:0]        head_cnt;
  logic [1:0]        head_cnt_next;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{currentPC[31:IDX_W+2], currentPC[1:0],
                            branchPC[31:IDX_W+2], branchPC[1:0]};

  assign ghr_ext    = IDX_W'(ghr);
  assign idx        = currentPC[IDX_W+1:2] ^ ghr_ext;
  assign pred_bit   = pht[idx][1];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  assign head_idx  = f_idx[rd_ptr];
  assign head_ghr  = f_ghr[rd_ptr];
  assign head_pred = f_pred[rd_ptr];

  // Handshake: a predict request (isbranch) is accepted when the FIFO has room
  // or is popped this cycle, unless a mispredict flush wins; an update is
  // accepted only when it matches the head entry, otherwise sync_err pulses.
  assign upd_hit  = update && !fifo_empty && (branchPC[IDX_W+1:2] == f_pc[rd_ptr]);
  assign upd_mis  = upd_hit && (taken != head_pred);
  assign pred_acc = isbranch && (!fifo_full || upd_hit) && !upd_mis;

  assign head_cnt = pht[head_idx];
  always_comb begin
    head_cnt_next = head_cnt;
    if (taken) begin
      if (head_cnt != 2'b11) head_cnt_next = head_cnt + 2'b01;
    end else begin
      if (head_cnt != 2'b00) head_cnt_next = head_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_ENT; i++) pht[i] <= 2'b01;
      ghr        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pred_taken <= 1'b0;
      pred_valid <= 1'b0;
      mispredict <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      pred_valid <= pred_acc;
      if (pred_acc) pred_taken <= pred_bit;
      mispredict <= upd_mis;
      sync_err   <= update && !upd_hit;

      // Non-blocking write keeps a same-cycle predict reading the old counter.
      if (upd_hit) pht[head_idx] <= head_cnt_next;

      if (upd_mis)       ghr <= {head_ghr[HIST_W-2:0], taken};
      else if (pred_acc) ghr <= {ghr[HIST_W-2:0], pred_bit};

      if (pred_acc) begin
        f_idx[wr_ptr]  <= idx;
        f_pc[wr_ptr]   <= currentPC[IDX_W+1:2];
        f_ghr[wr_ptr]  <= ghr;
        f_pred[wr_ptr] <= pred_bit;
      end

      if (upd_mis) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pred_acc) wr_ptr <= wr_ptr + 1'b1;
        if (upd_hit)  rd_ptr <= rd_ptr + 1'b1;
        case ({pred_acc, upd_hit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
